// File: rtl/me_unit_pkg.sv
// Shared CPU definitions for the memory stage: bus widths, memory-op and
// SRAM size encodings, ME state encoding and the EX->ME bus layout.
package me_unit_pkg;

    localparam int EX_ME_BUS_W = 75;
    localparam int ME_WB_BUS_W = 38;

    typedef enum logic [2:0] {
        MEM_W  = 3'd0,
        MEM_H  = 3'd1,
        MEM_HU = 3'd2,
        MEM_B  = 3'd3,
        MEM_BU = 3'd4
    } mem_op_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } sram_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } me_state_e;

    typedef struct packed {
        logic [2:0]  mem_op;
        logic        mem_we;
        logic [31:0] alu_result;
        logic [31:0] rkd_value;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
    } ex_me_bus_t;

    // Encodings 5-7 fall through to a word access.
    function automatic logic [1:0] size_of(input logic [2:0] op);
        case (op)
            MEM_H, MEM_HU: return SIZE_HALF;
            MEM_B, MEM_BU: return SIZE_BYTE;
            default:       return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/me_load_align.sv
// Picks the addressed byte/halfword out of the read word and extends it
// to 32 bits according to the load flavour.
module me_load_align
    import me_unit_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
    end

    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        // NOTE: default assignment first so every path drives the output and no latch is inferred.
        load_data = rdata;
        case (mem_op)
            MEM_B:   load_data = {{24{byte_sel[7]}}, byte_sel};
            MEM_BU:  load_data = {24'h0, byte_sel};
            MEM_H:   load_data = {{16{half_sel[15]}}, half_sel};
            MEM_HU:  load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/me_unit.sv
// Pipeline memory stage: accepts one instruction from EX, runs at most one
// data-SRAM transaction for it, and holds the result until WB takes it.
module me_unit
    import me_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   EX_Valid,
    input  logic [EX_ME_BUS_W-1:0] EX_to_ME_Bus,
    output logic                   ME_Unit_Ready,
    output logic                   ME_Valid,
    input  logic                   WB_Unit_Ready,
    output logic [ME_WB_BUS_W-1:0] ME_to_WB_Bus,
    output logic                   data_sram_req,
    output logic                   data_sram_wr,
    output logic [1:0]             data_sram_size,
    output logic [31:0]            data_sram_addr,
    output logic [3:0]             data_sram_wstrb,
    output logic [31:0]            data_sram_wdata,
    input  logic                   data_sram_addr_ok,
    input  logic                   data_sram_data_ok,
    input  logic [31:0]            data_sram_rdata
);

    me_state_e   state;
    ex_me_bus_t  ex_in;
    ex_me_bus_t  inst;
    logic [31:0] result;
    logic [31:0] load_data;
    logic        accept;

    assign ex_in = ex_me_bus_t'(EX_to_ME_Bus);

    // A finished result leaving for WB frees the stage in the same cycle.
    assign ME_Unit_Ready = (state == ST_IDLE) | ((state == ST_DONE) & WB_Unit_Ready);
    assign accept        = EX_Valid & ME_Unit_Ready;

    assign ME_Valid     = (state == ST_DONE);
    assign ME_to_WB_Bus = {inst.gr_we, inst.dest, result};

    // Request fields come only from the latched instruction, so they cannot
    // move while the request waits for addr_ok.
    assign data_sram_req  = (state == ST_REQ);
    assign data_sram_wr   = inst.mem_we;
    assign data_sram_addr = inst.alu_result;
    assign data_sram_size = size_of(inst.mem_op);

    always_comb begin
        data_sram_wstrb = 4'b1111;
        data_sram_wdata = inst.rkd_value;
        case (inst.mem_op)
            MEM_B, MEM_BU: begin
                data_sram_wstrb = 4'b0001 << inst.alu_result[1:0];
                data_sram_wdata = {4{inst.rkd_value[7:0]}};
            end
            MEM_H, MEM_HU: begin
                data_sram_wstrb = inst.alu_result[1] ? 4'b1100 : 4'b0011;
                data_sram_wdata = {2{inst.rkd_value[15:0]}};
            end
            default: ;
        endcase
        if (!inst.mem_we)
            data_sram_wstrb = 4'b0000;
    end

    me_load_align u_load_align (
        .mem_op    (inst.mem_op),
        .addr_lo   (inst.alu_result[1:0]),
        .rdata     (data_sram_rdata),
        .load_data (load_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            state  <= ST_IDLE;
            inst   <= '0;
            result <= '0;
        end else if (accept) begin
            inst <= ex_in;
            if (ex_in.res_from_mem | ex_in.mem_we) begin
                state <= ST_REQ;
            end else begin
                state  <= ST_DONE;
                result <= ex_in.alu_result;
            end
        end else begin
            case (state)
                ST_REQ:  if (data_sram_addr_ok) state <= ST_WAIT;
                ST_WAIT: if (data_sram_data_ok) begin
                    state  <= ST_DONE;
                    result <= inst.res_from_mem ? load_data : inst.alu_result;
                end
                ST_DONE: if (WB_Unit_Ready) state <= ST_IDLE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_me_unit.sv
// Directed, table-driven bench for me_unit plus hand-written sequences for
// backpressure, back-to-back issue and reset during an outstanding load.
module tb_me_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        EX_Valid;
    logic [74:0] EX_to_ME_Bus;
    logic        ME_Unit_Ready;
    logic        ME_Valid;
    logic        WB_Unit_Ready;
    logic [37:0] ME_to_WB_Bus;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    me_unit dut (
        .clk               (clk),
        .resetn            (resetn),
        .EX_Valid          (EX_Valid),
        .EX_to_ME_Bus      (EX_to_ME_Bus),
        .ME_Unit_Ready     (ME_Unit_Ready),
        .ME_Valid          (ME_Valid),
        .WB_Unit_Ready     (WB_Unit_Ready),
        .ME_to_WB_Bus      (ME_to_WB_Bus),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    typedef struct {
        logic [2:0]  op;
        logic        we;
        logic        rfm;
        logic [31:0] addr;
        logic [31:0] rkd;
        logic [31:0] rdata;
        logic        gr_we;
        logic [4:0]  dest;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] result;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [74:0] mk_bus(input logic [2:0] op, input logic we, input logic [31:0] alu,
                                           input logic [31:0] rkd, input logic rfm, input logic gr_we,
                                           input logic [4:0] dest);
        return {op, we, alu, rkd, rfm, gr_we, dest};
    endfunction

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        @(negedge clk);
        EX_Valid     = 1'b1;
        EX_to_ME_Bus = mk_bus(v.op, v.we, v.addr, v.rkd, v.rfm, v.gr_we, v.dest);
        #1;
        check($sformatf("v%0d_ready", i), 64'(ME_Unit_Ready), 64'd1);
        @(negedge clk);
        EX_Valid = 1'b0;
        #1;
        if (!(v.we | v.rfm)) begin
            check($sformatf("v%0d_valid", i), 64'(ME_Valid), 64'd1);
            check($sformatf("v%0d_noreq", i), 64'(data_sram_req), 64'd0);
            check($sformatf("v%0d_bus", i), 64'(ME_to_WB_Bus), 64'({v.gr_we, v.dest, v.result}));
        end else begin
            check($sformatf("v%0d_req", i), 64'(data_sram_req), 64'd1);
            check($sformatf("v%0d_wr", i), 64'(data_sram_wr), 64'(v.we));
            check($sformatf("v%0d_size", i), 64'(data_sram_size), 64'(v.size));
            check($sformatf("v%0d_addr", i), 64'(data_sram_addr), 64'(v.addr));
            if (v.we) begin
                check($sformatf("v%0d_wstrb", i), 64'(data_sram_wstrb), 64'(v.wstrb));
                check($sformatf("v%0d_wdata", i), 64'(data_sram_wdata), 64'(v.wdata));
            end
            data_sram_addr_ok = 1'b1;
            @(negedge clk);
            data_sram_addr_ok = 1'b0;
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = v.rdata;
            #1;
            check($sformatf("v%0d_wait_noreq", i), 64'(data_sram_req), 64'd0);
            @(negedge clk);
            data_sram_data_ok = 1'b0;
            #1;
            check($sformatf("v%0d_valid", i), 64'(ME_Valid), 64'd1);
            check($sformatf("v%0d_bus", i), 64'(ME_to_WB_Bus), 64'({v.gr_we, v.dest, v.result}));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          op     we    rfm   addr          rkd           rdata         gr_we dest   size   wstrb    wdata         result
        vecs[0]  = '{3'd0, 1'b0, 1'b0, 32'h12345678, 32'h0,        32'h0,        1'b1, 5'd5,  2'd0, 4'b0000, 32'h0,        32'h12345678};
        vecs[1]  = '{3'd3, 1'b0, 1'b1, 32'h00000103, 32'h0,        32'h80FFFF7F, 1'b1, 5'd7,  2'd0, 4'b0000, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{3'd4, 1'b0, 1'b1, 32'h00000103, 32'h0,        32'h80FFFF7F, 1'b1, 5'd7,  2'd0, 4'b0000, 32'h0,        32'h00000080};
        vecs[3]  = '{3'd1, 1'b0, 1'b1, 32'h00000102, 32'h0,        32'h80FFFF7F, 1'b1, 5'd8,  2'd1, 4'b0000, 32'h0,        32'hFFFF80FF};
        vecs[4]  = '{3'd2, 1'b0, 1'b1, 32'h00000100, 32'h0,        32'h12348001, 1'b1, 5'd9,  2'd1, 4'b0000, 32'h0,        32'h00008001};
        vecs[5]  = '{3'd0, 1'b0, 1'b1, 32'h00000104, 32'h0,        32'hDEADBEEF, 1'b1, 5'd10, 2'd2, 4'b0000, 32'h0,        32'hDEADBEEF};
        vecs[6]  = '{3'd4, 1'b0, 1'b1, 32'h00000101, 32'h0,        32'h11223344, 1'b1, 5'd11, 2'd0, 4'b0000, 32'h0,        32'h00000033};
        vecs[7]  = '{3'd1, 1'b1, 1'b0, 32'h00000202, 32'h0000BEEF, 32'h0,        1'b0, 5'd0,  2'd1, 4'b1100, 32'hBEEFBEEF, 32'h00000202};
        vecs[8]  = '{3'd3, 1'b1, 1'b0, 32'h00000301, 32'h123456AB, 32'h0,        1'b0, 5'd0,  2'd0, 4'b0010, 32'hABABABAB, 32'h00000301};
        vecs[9]  = '{3'd0, 1'b1, 1'b0, 32'h00000403, 32'hCAFEF00D, 32'h0,        1'b0, 5'd0,  2'd2, 4'b1111, 32'hCAFEF00D, 32'h00000403};
        vecs[10] = '{3'd7, 1'b0, 1'b1, 32'h00000500, 32'h0,        32'h89ABCDEF, 1'b1, 5'd12, 2'd2, 4'b0000, 32'h0,        32'h89ABCDEF};
        vecs[11] = '{3'd1, 1'b0, 1'b1, 32'h00000103, 32'h0,        32'hA5A51234, 1'b1, 5'd13, 2'd1, 4'b0000, 32'h0,        32'hFFFFA5A5};
        vecs[12] = '{3'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b0, 5'd31, 2'd0, 4'b0000, 32'h0,        32'hFFFFFFFF};
        vecs[13] = '{3'd4, 1'b1, 1'b0, 32'h00000003, 32'h0000005A, 32'h0,        1'b0, 5'd0,  2'd0, 4'b1000, 32'h5A5A5A5A, 32'h00000003};

        resetn            = 1'b0;
        EX_Valid          = 1'b0;
        EX_to_ME_Bus      = '0;
        WB_Unit_Ready     = 1'b1;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 64'(ME_Valid), 64'd0);
        check("rst_req", 64'(data_sram_req), 64'd0);
        check("rst_bus", 64'(ME_to_WB_Bus), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rst_release_ready", 64'(ME_Unit_Ready), 64'd1);

        for (int i = 0; i < NV; i++)
            run_vec(i);

        // Backpressure: addr_ok late by 3, data_ok late by 2, WB stalls 4.
        @(negedge clk);
        EX_Valid     = 1'b1;
        EX_to_ME_Bus = mk_bus(3'd0, 1'b0, 32'h00000600, 32'h0, 1'b1, 1'b1, 5'd3);
        @(negedge clk);
        EX_Valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            data_sram_data_ok = (j == 0);
            data_sram_rdata   = 32'hBAD0BAD0;
            #1;
            check($sformatf("bp_req_%0d", j), 64'(data_sram_req), 64'd1);
            check($sformatf("bp_addr_%0d", j), 64'(data_sram_addr), 64'h600);
            check($sformatf("bp_size_%0d", j), 64'(data_sram_size), 64'd2);
            check($sformatf("bp_wr_%0d", j), 64'(data_sram_wr), 64'd0);
            check($sformatf("bp_rdy_req_%0d", j), 64'(ME_Unit_Ready), 64'd0);
            check($sformatf("bp_val_req_%0d", j), 64'(ME_Valid), 64'd0);
            @(negedge clk);
        end
        data_sram_data_ok = 1'b0;
        data_sram_addr_ok = 1'b1;
        #1;
        check("bp_req_at_ok", 64'(data_sram_req), 64'd1);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            data_sram_addr_ok = 1'b0;
            #1;
            check($sformatf("bp_wait_noreq_%0d", j), 64'(data_sram_req), 64'd0);
            check($sformatf("bp_wait_val_%0d", j), 64'(ME_Valid), 64'd0);
            check($sformatf("bp_wait_rdy_%0d", j), 64'(ME_Unit_Ready), 64'd0);
        end
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h13579BDF;
        WB_Unit_Ready     = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'h0F0F0F0F;
            #1;
            check($sformatf("bp_hold_val_%0d", j), 64'(ME_Valid), 64'd1);
            check($sformatf("bp_hold_bus_%0d", j), 64'(ME_to_WB_Bus), 64'({1'b1, 5'd3, 32'h13579BDF}));
            check($sformatf("bp_hold_rdy_%0d", j), 64'(ME_Unit_Ready), 64'd0);
        end
        @(negedge clk);
        WB_Unit_Ready = 1'b1;
        #1;
        check("bp_release_rdy", 64'(ME_Unit_Ready), 64'd1);
        check("bp_release_val", 64'(ME_Valid), 64'd1);
        @(negedge clk);
        #1;
        check("bp_drained", 64'(ME_Valid), 64'd0);

        // Back-to-back: two ALU ops then a load, each accepted as DONE drains.
        EX_Valid     = 1'b1;
        EX_to_ME_Bus = mk_bus(3'd0, 1'b0, 32'h11111111, 32'h0, 1'b0, 1'b1, 5'd1);
        @(negedge clk);
        EX_to_ME_Bus = mk_bus(3'd0, 1'b0, 32'h22222222, 32'h0, 1'b0, 1'b1, 5'd2);
        #1;
        check("b2b_a_val", 64'(ME_Valid), 64'd1);
        check("b2b_a_bus", 64'(ME_to_WB_Bus), 64'({1'b1, 5'd1, 32'h11111111}));
        check("b2b_a_rdy", 64'(ME_Unit_Ready), 64'd1);
        @(negedge clk);
        EX_to_ME_Bus = mk_bus(3'd0, 1'b0, 32'h00000700, 32'h0, 1'b1, 1'b1, 5'd4);
        #1;
        check("b2b_b_val", 64'(ME_Valid), 64'd1);
        check("b2b_b_bus", 64'(ME_to_WB_Bus), 64'({1'b1, 5'd2, 32'h22222222}));
        check("b2b_b_rdy", 64'(ME_Unit_Ready), 64'd1);
        @(negedge clk);
        EX_Valid          = 1'b0;
        data_sram_addr_ok = 1'b1;
        #1;
        check("b2b_no_dup", 64'(ME_Valid), 64'd0);
        check("b2b_c_req", 64'(data_sram_req), 64'd1);
        check("b2b_c_addr", 64'(data_sram_addr), 64'h700);
        @(negedge clk);
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0A0B0C0D;
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        check("b2b_c_val", 64'(ME_Valid), 64'd1);
        check("b2b_c_bus", 64'(ME_to_WB_Bus), 64'({1'b1, 5'd4, 32'h0A0B0C0D}));
        @(negedge clk);
        #1;
        check("b2b_drained", 64'(ME_Valid), 64'd0);

        // Reset while a load sits in WAIT; a late data_ok must not revive it.
        EX_Valid     = 1'b1;
        EX_to_ME_Bus = mk_bus(3'd0, 1'b0, 32'h00000800, 32'h0, 1'b1, 1'b1, 5'd6);
        @(negedge clk);
        EX_Valid          = 1'b0;
        data_sram_addr_ok = 1'b1;
        #1;
        check("rw_req", 64'(data_sram_req), 64'd1);
        @(negedge clk);
        data_sram_addr_ok = 1'b0;
        #1;
        check("rw_in_wait_req", 64'(data_sram_req), 64'd0);
        check("rw_in_wait_rdy", 64'(ME_Unit_Ready), 64'd0);
        resetn = 1'b0;
        #1;
        check("rw_rst_val", 64'(ME_Valid), 64'd0);
        check("rw_rst_req", 64'(data_sram_req), 64'd0);
        check("rw_rst_bus", 64'(ME_to_WB_Bus), 64'd0);
        check("rw_rst_rdy", 64'(ME_Unit_Ready), 64'd1);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rw_release_rdy", 64'(ME_Unit_Ready), 64'd1);
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hFFFFFFFF;
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        check("rw_late_dok_val", 64'(ME_Valid), 64'd0);
        check("rw_late_dok_req", 64'(data_sram_req), 64'd0);
        check("rw_late_dok_bus", 64'(ME_to_WB_Bus), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
